// File: rtl/bus_endpoint.sv
// Bus endpoint: a TX FIFO drained by the bus and an RX FIFO filled by the bus, both first-word-fall-through.
// Optional destination-address filtering on RX is enabled by defining BUS_ENDPOINT_ADDR_FILTER_EN.
module bus_endpoint #(
  parameter int          pckg_sz   = 16,
  parameter int          depth     = 8,
  parameter logic [7:0]  id        = 8'h00,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               tx_wr,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_full,
  input  logic               rx_rd,
  output logic [pckg_sz-1:0] rx_data,
  output logic               rx_empty,
  output logic [7:0]         ovf_cnt,
  output logic [7:0]         drop_cnt
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [pckg_sz-1:0] tx_mem_q [depth];
  logic [pckg_sz-1:0] rx_mem_q [depth];

  ptr_t       tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  ptr_t       rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  cnt_t       tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [7:0] ovf_q, ovf_d;

  logic tx_pop_ok, tx_wr_ok, tx_full_w;
  logic rx_rd_ok, rx_st_ok, rx_ovf, rx_full_w, addr_ok;

`ifdef BUS_ENDPOINT_ADDR_FILTER_EN
  logic [7:0] drop_q, drop_d;
  logic [7:0] dest;
  assign dest    = D_push[pckg_sz-1 -: 8];
  assign addr_ok = (dest == id) || (dest == broadcast);
`else
  assign addr_ok = 1'b1;
`endif

  assign tx_full_w = (tx_cnt_q == cnt_t'(depth));
  assign rx_full_w = (rx_cnt_q == cnt_t'(depth));

  // A full FIFO still takes a write when the same edge frees a slot.
  assign tx_pop_ok = pop && (tx_cnt_q != '0);
  assign tx_wr_ok  = tx_wr && (!tx_full_w || tx_pop_ok);
  assign rx_rd_ok  = rx_rd && (rx_cnt_q != '0);
  assign rx_st_ok  = push && addr_ok && (!rx_full_w || rx_rd_ok);
  assign rx_ovf    = push && addr_ok && rx_full_w && !rx_rd_ok;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
    tx_cnt_d = tx_cnt_q;
    rx_cnt_d = rx_cnt_q;
    if (tx_wr_ok && !tx_pop_ok)      tx_cnt_d = tx_cnt_q + cnt_t'(1);
    else if (!tx_wr_ok && tx_pop_ok) tx_cnt_d = tx_cnt_q - cnt_t'(1);
    if (rx_st_ok && !rx_rd_ok)       rx_cnt_d = rx_cnt_q + cnt_t'(1);
    else if (!rx_st_ok && rx_rd_ok)  rx_cnt_d = rx_cnt_q - cnt_t'(1);

    // Power-of-two depth lets pointers wrap by natural overflow.
    tx_wp_d = tx_wr_ok  ? tx_wp_q + ptr_t'(1) : tx_wp_q;
    tx_rp_d = tx_pop_ok ? tx_rp_q + ptr_t'(1) : tx_rp_q;
    rx_wp_d = rx_st_ok  ? rx_wp_q + ptr_t'(1) : rx_wp_q;
    rx_rp_d = rx_rd_ok  ? rx_rp_q + ptr_t'(1) : rx_rp_q;

    ovf_d = (rx_ovf && ovf_q != 8'hFF) ? ovf_q + 8'd1 : ovf_q;
`ifdef BUS_ENDPOINT_ADDR_FILTER_EN
    drop_d = (push && !addr_ok && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
`endif
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      ovf_q    <= '0;
    end else begin
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: storage arrays are not reset; the zeroed counts make stale contents invisible.
  always_ff @(posedge clk) begin
    if (tx_wr_ok && !reset) tx_mem_q[tx_wp_q] <= tx_data;
    if (rx_st_ok && !reset) rx_mem_q[rx_wp_q] <= D_push;
  end

`ifdef BUS_ENDPOINT_ADDR_FILTER_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end
  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 8'd0;
`endif

  assign pndng    = (tx_cnt_q != '0);
  assign tx_full  = tx_full_w;
  assign rx_empty = (rx_cnt_q == '0);
  assign D_pop    = pndng    ? tx_mem_q[tx_rp_q] : '0;
  assign rx_data  = rx_empty ? '0 : rx_mem_q[rx_rp_q];
  assign ovf_cnt  = ovf_q;

endmodule

// File: doc/bus_endpoint.md
BUS_ENDPOINT -- requirements
Module: bus_endpoint

Interface
REQ-001 Parameter pckg_sz, default 16, packet width in bits; upper 8 bits hold destination ID.
REQ-002 Parameter depth, default 8, entries per FIFO (power of two, >=2).
REQ-003 Parameter id, default 0, this endpoint's 8-bit bus address.
REQ-004 Parameter broadcast, default 8'hFF, address accepted by every endpoint.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high; clears all state.
REQ-007 pndng  out  1  TX FIFO not empty; bus may pop.
REQ-008 D_pop  out  pckg_sz  TX FIFO head packet (first-word-fall-through).
REQ-009 pop  in  1  bus consumes D_pop this cycle.
REQ-010 push  in  1  bus delivers D_push this cycle.
REQ-011 D_push  in  pckg_sz  packet delivered by bus.
REQ-012 tx_wr  in  1  host writes tx_data into TX FIFO.
REQ-013 tx_data  in  pckg_sz  host packet to send.
REQ-014 tx_full  out  1  TX FIFO holds depth entries.
REQ-015 rx_rd  in  1  host consumes rx_data.
REQ-016 rx_data  out  pckg_sz  RX FIFO head packet (first-word-fall-through).
REQ-017 rx_empty  out  1  RX FIFO holds no entries.
REQ-018 ovf_cnt  out  8  RX packets lost to full RX FIFO, saturating.
REQ-019 drop_cnt  out  8  RX packets rejected by address filter, saturating.

Function
REQ-020 TX and RX FIFOs SHALL each track occupancy 0..depth with read/write pointers wrapping modulo depth.
REQ-021 pndng SHALL equal (TX count != 0), registered state only, no combinational path from pop.
REQ-022 D_pop SHALL show TX head when pndng=1 and all-zeros when pndng=0.
REQ-023 pop with pndng=1 SHALL remove the head at the edge; next entry visible next cycle; pop with pndng=0 SHALL be ignored.
REQ-024 tx_wr with tx_full=0 SHALL enqueue tx_data; tx_wr with tx_full=1 and pop=1 same cycle SHALL enqueue; tx_wr with tx_full=1 and pop=0 SHALL be discarded.
REQ-025 Simultaneous tx_wr and pop with TX count=0 SHALL leave the FIFO holding tx_data (pop ignored, write accepted).
REQ-026 push SHALL be accepted the same edge (zero wait); accepted packet visible on rx_data next cycle at earliest.
REQ-027 Accepted push with RX full and rx_rd=0 SHALL be lost and ovf_cnt SHALL increment, saturating at 255.
REQ-028 Push with RX full and rx_rd=1 same cycle SHALL be stored.
REQ-029 rx_data SHALL be all-zeros when rx_empty=1; rx_rd with rx_empty=1 SHALL be ignored.
REQ-030 Counters SHALL hold at 255 and never wrap.

Reset
REQ-031 On reset assertion, independent of clk: pointers and counts 0, pndng=0, tx_full=0, rx_empty=1, D_pop=0, rx_data=0, ovf_cnt=0, drop_cnt=0.
REQ-032 Reset mid-operation SHALL discard all queued packets; pop/push/tx_wr/rx_rd during reset SHALL be ignored.
REQ-033 First action SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-034 With BUS_ENDPOINT_ADDR_FILTER_EN defined, push whose D_push[pckg_sz-1:pckg_sz-8] equals neither id nor broadcast SHALL not be stored and SHALL increment drop_cnt (saturating); filtered packets SHALL never increment ovf_cnt.
REQ-035 Without BUS_ENDPOINT_ADDR_FILTER_EN, every push SHALL be handled per REQ-026..028 and drop_cnt SHALL be tied to 0.

Verification
REQ-036 Reset, write 3 packets 16'h0111,16'h0222,16'h0333 via tx_wr -> pndng=1, D_pop=16'h0111; three pops return 0222, 0333, then pndng=0, D_pop=0.
REQ-037 Write depth=8 packets, 9th tx_wr without pop -> tx_full=1, 9th discarded; 9th with pop same cycle -> accepted, tx_full stays 1.
REQ-038 id=2, filter on: push 16'h0255 then 16'h07AA then 16'hFF01 -> rx_data yields 0255, FF01; drop_cnt=1, ovf_cnt=0.
REQ-039 Filter off: 10 pushes without rx_rd -> 8 stored in order, ovf_cnt=2; 300 more -> ovf_cnt=255.
REQ-040 Assert reset with 5 TX and 4 RX entries queued -> pndng=0, rx_empty=1, counters 0 immediately, before next clk edge.
REQ-041 Push and rx_rd each cycle for 20 cycles with RX full -> no loss, ovf_cnt=0, order preserved across pointer wrap.
